ucode_checkpoint_monitor: RTL

UCODE_CHECKPOINT_MONITOR -- requirements
Module: ucode_checkpoint_monitor

---
 rtl/ucode_checkpoint_monitor.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ucode_checkpoint_monitor.sv
// Microcode checkpoint monitor: watches the execution/fetch stages and reports
// checkpoint hits, skip redirects, and whether a run passes, fails or times out.
module ucode_checkpoint_monitor #(
  parameter int PC_W  = 12,
  parameter int N_CHK = 16,
  parameter int N_SKIP = 8,
  parameter int N_FAIL = 4,
  parameter int CNT_W = 32,
  localparam int CFG_W   = 3 * PC_W + 1,
  localparam int CHK_IW  = (N_CHK > 1) ? $clog2(N_CHK) : 1,
  localparam int FAIL_IW = (N_FAIL > 1) ? $clog2(N_FAIL) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic               x_valid_i,
  input  logic [PC_W-1:0]    pc_x_i,
  input  logic [PC_W-1:0]    pc_f_i,
  input  logic [3:0]         op_sqi_i,
  input  logic [1:0]         op_map_i,
  input  logic [PC_W-1:0]    op_a_i,
  input  logic               cfg_we_i,
  input  logic [1:0]         cfg_tbl_i,
  input  logic [7:0]         cfg_idx_i,
  input  logic [CFG_W-1:0]   cfg_data_i,
  output logic               cfg_err_o,
  output logic [2:0]         state_o,
  output logic               done_o,
  output logic               pass_valid_o,
  output logic [CHK_IW-1:0]  pass_idx_o,
  output logic [CHK_IW:0]    pass_count_o,
  output logic               redirect_valid_o,
  output logic [PC_W-1:0]    redirect_target_o,
  output logic [FAIL_IW-1:0] fail_idx_o,
  output logic [CNT_W-1:0]   cycles_o
);

  localparam int SKIP_IW = (N_SKIP > 1) ? $clog2(N_SKIP) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [N_CHK-1:0]  chkValid_q;
  logic [PC_W-1:0]   chkLabel_q [N_CHK];
  logic [N_SKIP-1:0] skipValid_q;
  logic [PC_W-1:0]   skipFrom_q [N_SKIP];
  logic [PC_W-1:0]   skipTo_q [N_SKIP];
  logic [PC_W-1:0]   skipTarget_q [N_SKIP];
  logic [N_FAIL-1:0] failValid_q;
  logic [PC_W-1:0]   failLabel_q [N_FAIL];
  logic [CNT_W-1:0]  limit_q;
  logic              endValid_q;
  logic [PC_W-1:0]   endLabel_q;

  logic               cfgErr_q, cfgErr_d;
  logic               done_q, done_d;
  logic               passValid_q, passValid_d;
  logic [CHK_IW-1:0]  passIdx_q, passIdx_d;
  logic [CHK_IW:0]    passCount_q, passCount_d;
  logic [N_CHK-1:0]   chkHit_q, chkHit_d;
  logic               redirValid_q, redirValid_d;
  logic [PC_W-1:0]    redirTarget_q, redirTarget_d;
  logic [FAIL_IW-1:0] failIdx_q, failIdx_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;

  logic cfgInRange;
  logic cfgAccept;

  // Configuration is only accepted outside RUN and for indices inside the table.
  always_comb begin
    cfgInRange = 1'b0;
    unique case (cfg_tbl_i)
      2'd0: cfgInRange = (int'(cfg_idx_i) < N_CHK);
      2'd1: cfgInRange = (int'(cfg_idx_i) < N_SKIP);
      2'd2: cfgInRange = (int'(cfg_idx_i) < N_FAIL);
      2'd3: cfgInRange = (int'(cfg_idx_i) < 2);
    endcase
    cfgAccept = cfg_we_i && (state_q != ST_RUN) && cfgInRange;
    cfgErr_d  = cfg_we_i && !cfgAccept;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chkValid_q  <= '0;
      skipValid_q <= '0;
      failValid_q <= '0;
      limit_q     <= '0;
      endValid_q  <= 1'b0;
    end else if (cfgAccept) begin
      unique case (cfg_tbl_i)
        2'd0: begin
          chkValid_q[cfg_idx_i[CHK_IW-1:0]] <= cfg_data_i[PC_W];
          chkLabel_q[cfg_idx_i[CHK_IW-1:0]] <= cfg_data_i[PC_W-1:0];
        end
        2'd1: begin
          skipValid_q[cfg_idx_i[SKIP_IW-1:0]]  <= cfg_data_i[3*PC_W];
          skipFrom_q[cfg_idx_i[SKIP_IW-1:0]]   <= cfg_data_i[3*PC_W-1:2*PC_W];
          skipTo_q[cfg_idx_i[SKIP_IW-1:0]]     <= cfg_data_i[2*PC_W-1:PC_W];
          skipTarget_q[cfg_idx_i[SKIP_IW-1:0]] <= cfg_data_i[PC_W-1:0];
        end
        2'd2: begin
          failValid_q[cfg_idx_i[FAIL_IW-1:0]] <= cfg_data_i[PC_W];
          failLabel_q[cfg_idx_i[FAIL_IW-1:0]] <= cfg_data_i[PC_W-1:0];
        end
        2'd3: begin
          if (cfg_idx_i == 8'd0) begin
            limit_q <= cfg_data_i[CNT_W-1:0];
          end else begin
            endValid_q <= cfg_data_i[PC_W];
            endLabel_q <= cfg_data_i[PC_W-1:0];
          end
        end
      endcase
    end
  end

  logic               failHit, endHit, timeoutHit, chkMatch, skipMatch;
  logic [FAIL_IW-1:0] failSel;
  logic [CHK_IW-1:0]  chkSel;
  logic [PC_W-1:0]    skipSel;
  logic [CNT_W:0]     cyclesInc;

  // Descending loops let the lowest matching index win.
  always_comb begin
    failHit   = 1'b0;
    failSel   = '0;
    chkMatch  = 1'b0;
    chkSel    = '0;
    skipMatch = 1'b0;
    skipSel   = '0;
    for (int i = N_FAIL - 1; i >= 0; i--) begin
      if (x_valid_i && failValid_q[i] && (failLabel_q[i] == pc_x_i)) begin
        failHit = 1'b1;
        failSel = FAIL_IW'(i);
      end
    end
    for (int i = N_CHK - 1; i >= 0; i--) begin
      if (x_valid_i && (op_sqi_i == 4'd14) && (op_map_i == 2'd0) &&
          chkValid_q[i] && (chkLabel_q[i] == op_a_i)) begin
        chkMatch = 1'b1;
        chkSel   = CHK_IW'(i);
      end
    end
    for (int i = N_SKIP - 1; i >= 0; i--) begin
      if (x_valid_i && !redirValid_q && skipValid_q[i] &&
          (skipFrom_q[i] == pc_x_i) && (skipTo_q[i] == pc_f_i)) begin
        skipMatch = 1'b1;
        skipSel   = skipTarget_q[i];
      end
    end
    endHit     = x_valid_i && endValid_q && (pc_x_i == endLabel_q);
    cyclesInc  = {1'b0, cycles_q} + {{CNT_W{1'b0}}, 1'b1};
    timeoutHit = (limit_q != '0) && (cyclesInc == {1'b0, limit_q});
  end

  // Exits from RUN freeze the cycle count and swallow same-cycle events.
  always_comb begin
    state_d       = state_q;
    cycles_d      = cycles_q;
    passValid_d   = 1'b0;
    passIdx_d     = passIdx_q;
    passCount_d   = passCount_q;
    chkHit_d      = chkHit_q;
    redirValid_d  = 1'b0;
    redirTarget_d = redirTarget_q;
    failIdx_d     = failIdx_q;
    if (start_i) begin
      state_d     = ST_RUN;
      cycles_d    = '0;
      passCount_d = '0;
      chkHit_d    = '0;
    end else if (state_q == ST_RUN) begin
      if (failHit) begin
        state_d   = ST_FAIL;
        failIdx_d = failSel;
      end else if (endHit) begin
        state_d = ST_PASS;
      end else if (timeoutHit) begin
        state_d = ST_TIMEOUT;
      end else begin
        cycles_d = cyclesInc[CNT_W] ? cycles_q : cyclesInc[CNT_W-1:0];
        if (chkMatch) begin
          passValid_d = 1'b1;
          passIdx_d   = chkSel;
          if (!chkHit_q[chkSel]) begin
            chkHit_d[chkSel] = 1'b1;
            passCount_d      = passCount_q + (CHK_IW + 1)'(1);
          end
        end
        if (skipMatch) begin
          redirValid_d  = 1'b1;
          redirTarget_d = skipSel;
        end
      end
    end
    done_d = (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cfgErr_q      <= 1'b0;
      done_q        <= 1'b0;
      passValid_q   <= 1'b0;
      passIdx_q     <= '0;
      passCount_q   <= '0;
      chkHit_q      <= '0;
      redirValid_q  <= 1'b0;
      redirTarget_q <= '0;
      failIdx_q     <= '0;
      cycles_q      <= '0;
    end else begin
      state_q       <= state_d;
      cfgErr_q      <= cfgErr_d;
      done_q        <= done_d;
      passValid_q   <= passValid_d;
      passIdx_q     <= passIdx_d;
      passCount_q   <= passCount_d;
      chkHit_q      <= chkHit_d;
      redirValid_q  <= redirValid_d;
      redirTarget_q <= redirTarget_d;
      failIdx_q     <= failIdx_d;
      cycles_q      <= cycles_d;
    end
  end

  assign state_o           = state_q;
  assign cfg_err_o         = cfgErr_q;
  assign done_o            = done_q;
  assign pass_valid_o      = passValid_q;
  assign pass_idx_o        = passIdx_q;
  assign pass_count_o      = passCount_q;
  assign redirect_valid_o  = redirValid_q;
  assign redirect_target_o = redirTarget_q;
  assign fail_idx_o        = failIdx_q;
  assign cycles_o          = cycles_q;

endmodule
